lsu_mem_initiator: RTL and testbench

- Load/store initiator between the pipeline memory stage and the byte-addressed data memory.
- Accepts one load or store request per transaction through a valid/ready handshake and drives the data memory port (write enable, read enable, address, write data, access size).
- Sign- or zero-extends load data and returns a response through a valid/ready handshake.
- Misaligned halfword/word accesses are either split into sequential byte accesses or rejected with an error flag, selected by a parameter.

---
 rtl/lsu_mem_initiator.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
// Load/store initiator sitting between the pipeline memory stage and a
// byte-addressed data memory. One request is accepted per transaction,
// performed on the memory port (possibly as a sequence of byte beats when the
// access is misaligned) and answered with an extended load value or an error.

package lsu_mem_pkg;
    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10
    } mem_op_sz_e;
endpackage

module lsu_mem_initiator
    import lsu_mem_pkg::*;
#(
    parameter bit          SplitMisaligned = 1'b1,
    parameter int unsigned AddrLimit       = 32'd16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic        i_req_signed,
    input  mem_op_sz_e  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_we,
    output logic        o_mem_re,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output mem_op_sz_e  o_mem_size,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e      state_r;
    state_e      state_s;

    // latched request and transaction progress
    logic        store_r;
    logic        signed_r;
    mem_op_sz_e  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  cnt_r;
    logic [31:0] asm_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    // request decode
    logic [2:0]  nbytes_s;
    logic        size_ok_s;
    logic        aligned_s;
    logic [32:0] last_addr_s;
    logic        range_ok_s;
    logic        err_s;
    logic        split_s;
    logic        last_beat_s;
    logic [31:0] beat_addr_s;
    logic [7:0]  beat_wdata_s;
    logic [31:0] asm_next_s;
    logic [31:0] load_word_s;

    // Sign/zero extension of a raw little-endian load word to 32 bits.
    function automatic logic [31:0] extend_load(input mem_op_sz_e sz,
                                                input logic sgn,
                                                input logic [31:0] w);
        logic [31:0] r;
        case (sz)
            BYTE:    r = {{24{sgn & w[7]}}, w[7:0]};
            HWORD:   r = {{16{sgn & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Decode the latched request: size, alignment, range and current split beat.
    always_comb begin
        nbytes_s  = 3'd1;
        size_ok_s = 1'b0;
        aligned_s = 1'b1;
        case (size_r)
            BYTE: begin
                nbytes_s  = 3'd1;
                size_ok_s = 1'b1;
                aligned_s = 1'b1;
            end
            HWORD: begin
                nbytes_s  = 3'd2;
                size_ok_s = 1'b1;
                aligned_s = ~addr_r[0];
            end
            WORD: begin
                nbytes_s  = 3'd4;
                size_ok_s = 1'b1;
                aligned_s = (addr_r[1:0] == 2'b00);
            end
            default: begin
                nbytes_s  = 3'd1;
                size_ok_s = 1'b0;
                aligned_s = 1'b1;
            end
        endcase

        // 33-bit sum: a carry into bit 32 means the access wrapped the address space
        last_addr_s = {1'b0, addr_r} + {30'd0, nbytes_s} - 33'd1;
        range_ok_s  = ~last_addr_s[32] & (last_addr_s < 33'(AddrLimit));
        err_s       = ~size_ok_s | ~range_ok_s | (~aligned_s & ~SplitMisaligned);
        split_s     = ~aligned_s;

        if (err_s || !split_s) begin
            last_beat_s = 1'b1;
        end else begin
            last_beat_s = ({1'b0, cnt_r} == (nbytes_s - 3'd1));
        end

        beat_addr_s  = addr_r + {30'd0, cnt_r};
        beat_wdata_s = wdata_r[{cnt_r, 3'b000} +: 8];

        // assembly word including the byte arriving in this beat
        asm_next_s = asm_r;
        asm_next_s[{cnt_r, 3'b000} +: 8] = i_mem_rdata[7:0];

        if (split_s) begin
            load_word_s = asm_next_s;
        end else begin
            load_word_s = i_mem_rdata;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req_valid) begin
                    state_s = ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (last_beat_s) begin
                    state_s = RSP;
                end else begin
                    state_s = ACC;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake and memory-port outputs decoded from the current state.
    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        o_mem_size  = BYTE;
        case (state_r)
            IDLE: o_req_ready = ~i_rst;
            ACC: begin
                if (err_s) begin
                    o_mem_we = 1'b0;
                    o_mem_re = 1'b0;
                end else if (split_s) begin
                    o_mem_we    = store_r;
                    o_mem_re    = ~store_r;
                    o_mem_addr  = beat_addr_s;
                    o_mem_wdata = {24'd0, beat_wdata_s};
                    o_mem_size  = BYTE;
                end else begin
                    o_mem_we    = store_r;
                    o_mem_re    = ~store_r;
                    o_mem_addr  = addr_r;
                    o_mem_wdata = wdata_r;
                    o_mem_size  = size_r;
                end
            end
            RSP: o_rsp_valid = 1'b1;
            default: o_req_ready = 1'b0;
        endcase
    end

    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_err   = rsp_err_r;

    // Request latch, split-beat counter, load assembly and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            store_r     <= 1'b0;
            signed_r    <= 1'b0;
            size_r      <= BYTE;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            cnt_r       <= 2'd0;
            asm_r       <= 32'd0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_valid) begin
                        store_r     <= i_req_store;
                        signed_r    <= i_req_signed;
                        size_r      <= i_req_size;
                        addr_r      <= i_req_addr;
                        wdata_r     <= i_req_wdata;
                        cnt_r       <= 2'd0;
                        asm_r       <= 32'd0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ACC: begin
                    if (err_s) begin
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'd0;
                    end else begin
                        rsp_err_r <= 1'b0;
                        if (split_s) begin
                            asm_r <= asm_next_s;
                            cnt_r <= cnt_r + 2'd1;
                        end else begin
                            asm_r <= asm_r;
                        end
                        if (last_beat_s) begin
                            rsp_rdata_r <= store_r ? 32'd0
                                                   : extend_load(size_r, signed_r, load_word_s);
                        end else begin
                            rsp_rdata_r <= rsp_rdata_r;
                        end
                    end
                end
                default: begin
                    rsp_rdata_r <= rsp_rdata_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed scenarios plus random
// transactions checked against a transaction-level model of the data memory.
module tb_lsu_mem_initiator;
    import lsu_mem_pkg::*;

    localparam int LIM = 16;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_valid0, req_store, req_signed;
    mem_op_sz_e  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_ready, rsp_ready0;

    logic        req_ready, rsp_valid, rsp_err, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    mem_op_sz_e  mem_size;

    logic        req_ready0, rsp_valid0, rsp_err0, mem_we0, mem_re0;
    logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    mem_op_sz_e  mem_size0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem     [0:LIM-1];
    logic [7:0] ref_mem [0:LIM-1];

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } strobe_t;
    strobe_t slog[$];
    int      strobes0 = 0;

    lsu_mem_initiator #(.SplitMisaligned(1'b1), .AddrLimit(LIM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_store(req_store), .i_req_signed(req_signed), .i_req_size(req_size),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_size(mem_size), .i_mem_rdata(mem_rdata)
    );

    lsu_mem_initiator #(.SplitMisaligned(1'b0), .AddrLimit(LIM)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_store(req_store), .i_req_signed(req_signed), .i_req_size(req_size),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
        .o_rsp_rdata(rsp_rdata0), .o_rsp_err(rsp_err0),
        .o_mem_we(mem_we0), .o_mem_re(mem_re0), .o_mem_addr(mem_addr0),
        .o_mem_wdata(mem_wdata0), .o_mem_size(mem_size0), .i_mem_rdata(mem_rdata0)
    );

    assign mem_rdata0 = 32'hA5A5_A5A5;

    function automatic int nb(input mem_op_sz_e s);
        case (s)
            BYTE:    return 1;
            HWORD:   return 2;
            WORD:    return 4;
            default: return 1;
        endcase
    endfunction

    // combinational data memory read
    always_comb begin
        mem_rdata = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (b < nb(mem_size) && (mem_addr + 32'(b)) < 32'(LIM))
                mem_rdata[8*b +: 8] = mem[mem_addr + 32'(b)];
        end
    end

    // data memory write port
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (b < nb(mem_size) && (mem_addr + 32'(b)) < 32'(LIM))
                    mem[mem_addr + 32'(b)] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // strobe monitors
    always @(negedge clk) begin
        if (mem_we || mem_re) slog.push_back({mem_we, mem_re, mem_addr, mem_wdata, 2'(mem_size)});
        if (mem_we0 || mem_re0) strobes0++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic init_mem;
        for (int i = 0; i < LIM; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
    endtask

    // Transaction-level model: expected response, latency and strobe count.
    task automatic model(input bit st, input bit sg, input mem_op_sz_e sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] erd, output logic eer, output int elat,
                         output int nstrb, output bit esplit);
        int     n;
        bit     szok;
        longint v;
        n      = nb(sz);
        szok   = (sz == BYTE) || (sz == HWORD) || (sz == WORD);
        esplit = (a % 32'(n)) != 32'd0;
        eer    = !szok || (longint'({32'd0, a}) + longint'(n) > longint'(LIM));
        erd    = 32'd0;
        if (eer) begin
            elat  = 2;
            nstrb = 0;
        end else begin
            nstrb = esplit ? n : 1;
            elat  = esplit ? n + 1 : 2;
            if (st) begin
                for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[a + 32'(k)]) << (8*k));
                if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
                erd = v[31:0];
            end
        end
    endtask

    // Drive one request to the split-capable instance and observe its response.
    task automatic xact(input bit st, input bit sg, input mem_op_sz_e sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int g;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        slog.delete();
        req_valid = 1'b1; req_store = st; req_signed = sg; req_size = sz;
        req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b1; rsp_ready0 = 1'b1;
        req_store = 1'b0; req_signed = 1'b0; req_size = BYTE; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready act=%b exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp act=%b%b exp=00", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata act=%h exp=0", rsp_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_size !== BYTE) begin
            failures++; $display("FAIL reset_mem act=%b%b %h %h %0d exp=00 0 0 0", mem_we, mem_re, mem_addr, mem_wdata, mem_size);
        end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready act=%b exp=1", req_ready); end
    endtask

    task automatic test_aligned_word;
        logic [31:0] rd, erd; logic er, eer; int lat, elat, ns; bit sp;
        model(1'b1, 1'b0, WORD, 32'd4, 32'hDEADBEEF, erd, eer, elat, ns, sp);
        xact(1'b1, 1'b0, WORD, 32'd4, 32'hDEADBEEF, rd, er, lat);
        checks++; if (slog.size() != 1) begin failures++; $display("FAIL sw_strobes act=%0d exp=1", slog.size()); end
        else begin
            checks++; if (slog[0].we !== 1'b1 || slog[0].re !== 1'b0 || slog[0].size !== 2'(WORD) || slog[0].addr !== 32'd4 || slog[0].wdata !== 32'hDEADBEEF) begin
                failures++; $display("FAIL sw_port act=%b%b %0d %h %h exp=10 2 4 deadbeef", slog[0].we, slog[0].re, slog[0].size, slog[0].addr, slog[0].wdata);
            end
        end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw_rsp act=%b %h exp=0 0", er, rd); end
        model(1'b0, 1'b1, WORD, 32'd4, 32'd0, erd, eer, elat, ns, sp);
        xact(1'b0, 1'b1, WORD, 32'd4, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL lw_data act=%h %b exp=deadbeef 0", rd, er); end
        checks++; if (lat != 2) begin failures++; $display("FAIL lw_latency act=%0d exp=2", lat); end
        checks++; if (slog.size() != 1 || slog[0].re !== 1'b1 || slog[0].we !== 1'b0) begin failures++; $display("FAIL lw_strobes act=%0d exp=1 read", slog.size()); end
    endtask

    task automatic test_load_ext;
        logic [31:0] rd, erd; logic er, eer; int lat, elat, ns; bit sp;
        mem[2] = 8'h80; ref_mem[2] = 8'h80;
        mem[3] = 8'h7F; ref_mem[3] = 8'h7F;
        xact(1'b0, 1'b1, BYTE, 32'd2, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed act=%h exp=ffffff80", rd); end
        xact(1'b0, 1'b0, BYTE, 32'd2, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lb_unsigned act=%h exp=00000080", rd); end
        xact(1'b0, 1'b1, HWORD, 32'd2, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00007F80 || er !== 1'b0) begin failures++; $display("FAIL lh_signed act=%h %b exp=00007f80 0", rd, er); end
        model(1'b0, 1'b1, HWORD, 32'd2, 32'd0, erd, eer, elat, ns, sp);
    endtask

    task automatic test_split;
        logic [31:0] rd, erd; logic er, eer; int lat, elat, ns; bit sp;
        logic [31:0] wd;
        wd = 32'h11223344;
        model(1'b1, 1'b0, WORD, 32'd5, wd, erd, eer, elat, ns, sp);
        xact(1'b1, 1'b0, WORD, 32'd5, wd, rd, er, lat);
        checks++; if (slog.size() != 4) begin failures++; $display("FAIL split_sw_count act=%0d exp=4", slog.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (slog[k].we !== 1'b1 || slog[k].size !== 2'(BYTE) || slog[k].addr !== 32'(5 + k) || slog[k].wdata[7:0] !== wd[8*k +: 8]) begin
                    failures++; $display("FAIL split_sw_beat%0d act=%b %0d %h %h exp=1 0 %h %h", k, slog[k].we, slog[k].size, slog[k].addr, slog[k].wdata[7:0], 32'(5 + k), wd[8*k +: 8]);
                end
            end
        end
        checks++; if (lat != 5 || er !== 1'b0) begin failures++; $display("FAIL split_sw_latency act=%0d %b exp=5 0", lat, er); end
        model(1'b0, 1'b0, WORD, 32'd5, 32'd0, erd, eer, elat, ns, sp);
        xact(1'b0, 1'b0, WORD, 32'd5, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h11223344 || lat != 5) begin failures++; $display("FAIL split_lw act=%h lat=%0d exp=11223344 lat=5", rd, lat); end
    endtask

    task automatic test_reject;
        int lat;
        @(negedge clk);
        strobes0 = 0;
        req_store = 1'b0; req_signed = 1'b1; req_size = HWORD; req_addr = 32'd3; req_wdata = 32'd0;
        req_valid0 = 1'b1; rsp_ready0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0; lat = 1;
        while (!rsp_valid0 && lat < 12) begin @(negedge clk); lat++; end
        checks++; if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b1 || rsp_rdata0 !== 32'd0) begin
            failures++; $display("FAIL reject_lh act=%b %b %h exp=1 1 0", rsp_valid0, rsp_err0, rsp_rdata0);
        end
        checks++; if (strobes0 != 0) begin failures++; $display("FAIL reject_strobes act=%0d exp=0", strobes0); end
        @(negedge clk);
        strobes0 = 0;
        req_size = WORD; req_addr = 32'd4; req_signed = 1'b0;
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0; lat = 1;
        while (!rsp_valid0 && lat < 12) begin @(negedge clk); lat++; end
        checks++; if (rsp_err0 !== 1'b0 || rsp_rdata0 !== 32'hA5A5A5A5 || strobes0 != 1 || lat != 2) begin
            failures++; $display("FAIL reject_aligned_lw act=%b %h %0d %0d exp=0 a5a5a5a5 1 2", rsp_err0, rsp_rdata0, strobes0, lat);
        end
    endtask

    task automatic test_range_hold;
        logic [31:0] erd; logic eer; int lat, elat, ns; bit sp;
        @(negedge clk);
        slog.delete();
        req_store = 1'b0; req_signed = 1'b0; req_size = WORD; req_addr = 32'd14; req_wdata = 32'd0;
        rsp_ready = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; lat = 1;
        while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || slog.size() != 0) begin
            failures++; $display("FAIL range_err act=%b %h %0d exp=1 0 0", rsp_err, rsp_rdata, slog.size());
        end
        model(1'b0, 1'b0, BYTE, 32'd0, 32'd0, erd, eer, elat, ns, sp);
        req_size = BYTE; req_addr = 32'd0; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || req_ready !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d act=%b %b %h %b exp=1 1 0 0", c, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_release act=%b %b exp=0 1", rsp_valid, req_ready); end
        @(negedge clk);
        req_valid = 1'b0; lat = 1;
        while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
        checks++; if (rsp_rdata !== erd || rsp_err !== 1'b0 || slog.size() != 1) begin
            failures++; $display("FAIL held_req act=%h %b %0d exp=%h 0 1", rsp_rdata, rsp_err, slog.size(), erd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] wd; logic [7:0] o11;
        wd = $urandom;
        o11 = mem[11];
        @(negedge clk);
        req_store = 1'b1; req_signed = 1'b0; req_size = WORD; req_addr = 32'd9; req_wdata = wd;
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL mid_reset act=%b %b %b %b exp=0 0 0 0", mem_we, mem_re, rsp_valid, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready act=%b exp=1", req_ready); end
        checks++; if (mem[9] !== wd[7:0] || mem[11] !== o11) begin
            failures++; $display("FAIL mid_reset_mem act=%h %h exp=%h %h", mem[9], mem[11], wd[7:0], o11);
        end
        init_mem();
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, wd; logic er, eer; int lat, elat, ns, sel; bit sp, st, sg;
        mem_op_sz_e sz;
        for (int i = 0; i < 80; i++) begin
            st  = 1'($urandom);
            sg  = 1'($urandom);
            sel = $urandom_range(0, 9);
            sz  = (sel < 3) ? BYTE : (sel < 6) ? HWORD : (sel < 9) ? WORD : mem_op_sz_e'(2'b11);
            a   = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : 32'($urandom_range(0, 17));
            wd  = $urandom;
            model(st, sg, sz, a, wd, erd, eer, elat, ns, sp);
            xact(st, sg, sz, a, wd, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat || slog.size() != ns) begin
                failures++; $display("FAIL rand%0d st=%b sz=%0d a=%h act=%h %b %0d %0d exp=%h %b %0d %0d", i, st, sz, a, rd, er, lat, slog.size(), erd, eer, elat, ns);
            end else begin
                for (int k = 0; k < ns; k++) begin
                    checks++;
                    if (slog[k].we !== st || slog[k].re !== !st || slog[k].addr !== (sp ? a + 32'(k) : a) ||
                        slog[k].size !== (sp ? 2'(BYTE) : 2'(sz)) ||
                        (st && sp && slog[k].wdata[7:0] !== wd[8*k +: 8]) || (st && !sp && slog[k].wdata !== wd)) begin
                        failures++; $display("FAIL rand%0d_beat%0d act=%b%b %h %0d %h", i, k, slog[k].we, slog[k].re, slog[k].addr, slog[k].size, slog[k].wdata);
                    end
                end
            end
        end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_aligned_word();
        test_load_ext();
        test_split();
        test_reject();
        test_range_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
